// File: rtl/vend_state_ctrl.sv
// ============================================================================
// vend_state_ctrl : coin/credit FSM feeding the vending output-decode stage
// Revision 1.0
// ============================================================================
`default_nettype none

module vend_state_ctrl #(
   parameter int PRICE          = 15,
   parameter int CREDIT_W       = 6,
   parameter int HOLD_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                coin_5,
   input  logic                coin_10,
   input  logic                cancel,
   output logic [1:0]          current_state,
   output logic [CREDIT_W-1:0] change_amt,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_reject,
   output logic                busy
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CREDIT_W:0]   C_PRICE     = (CREDIT_W+1)'(PRICE);
   localparam logic [HOLD_W-1:0]   C_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [TMO_W-1:0]    C_TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_COLLECT  = 3'd1,
      S_REFUND   = 3'd2,
      S_VEND     = 3'd3,
      S_VEND_CHG = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          code_q, code_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] change_q, change_d;
   logic                reject_q, reject_d;
   logic                busy_q, busy_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;

   logic                w_collecting;
   logic                w_accept;
   logic [CREDIT_W:0]   w_coin_val;
   logic [CREDIT_W:0]   w_sum;
   logic [CREDIT_W-1:0] w_excess;

   // A coin counts only when it is the sole coin, cancel is low and we are not busy.
   assign w_collecting = (state_q == S_IDLE) || (state_q == S_COLLECT);
   assign w_accept     = w_collecting && (coin_5 ^ coin_10) && !cancel;
   assign w_coin_val   = coin_10 ? (CREDIT_W+1)'(10) : (CREDIT_W+1)'(5);
   assign w_sum        = {1'b0, credit_q} + w_coin_val;
   assign w_excess     = w_sum[CREDIT_W-1:0] - C_PRICE[CREDIT_W-1:0];

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      credit_d = credit_q;
      change_d = change_q;
      busy_d   = busy_q;
      hold_d   = hold_q;
      tmo_d    = tmo_q;
      reject_d = (coin_5 || coin_10) && !w_accept;

      case (state_q)
         S_IDLE, S_COLLECT: begin
            if (w_accept) begin
               credit_d = w_sum[CREDIT_W-1:0];
               tmo_d    = '0;
               hold_d   = '0;
               if (w_sum < C_PRICE) begin
                  state_d = S_COLLECT;
                  code_d  = 2'b00;
                  busy_d  = 1'b0;
               end else if (w_sum == C_PRICE) begin
                  state_d  = S_VEND;
                  code_d   = 2'b10;
                  change_d = '0;
                  busy_d   = 1'b1;
               end else begin
                  state_d  = S_VEND_CHG;
                  code_d   = 2'b11;
                  change_d = w_excess;
                  busy_d   = 1'b1;
               end
            end else if (state_q == S_COLLECT) begin
               // Cancel and timeout landing together still give one refund.
               if (cancel || (tmo_q == C_TMO_LAST)) begin
                  state_d  = S_REFUND;
                  code_d   = 2'b01;
                  change_d = credit_q;
                  busy_d   = 1'b1;
                  hold_d   = '0;
                  tmo_d    = '0;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end else begin
               tmo_d = '0;
            end
         end

         S_REFUND, S_VEND, S_VEND_CHG: begin
            if (hold_q == C_HOLD_LAST) begin
               state_d  = S_IDLE;
               code_d   = 2'b00;
               credit_d = '0;
               change_d = '0;
               busy_d   = 1'b0;
               hold_d   = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end

         default: begin
            state_d  = S_IDLE;
            code_d   = 2'b00;
            credit_d = '0;
            change_d = '0;
            busy_d   = 1'b0;
            hold_d   = '0;
            tmo_d    = '0;
            reject_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         code_q   <= 2'b00;
         credit_q <= '0;
         change_q <= '0;
         reject_q <= 1'b0;
         busy_q   <= 1'b0;
         hold_q   <= '0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         credit_q <= credit_d;
         change_q <= change_d;
         reject_q <= reject_d;
         busy_q   <= busy_d;
         hold_q   <= hold_d;
         tmo_q    <= tmo_d;
      end
   end

   assign current_state = code_q;
   assign change_amt    = change_q;
   assign credit        = credit_q;
   assign coin_reject   = reject_q;
   assign busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_vend_state_ctrl.sv
// ============================================================================
// tb_vend_state_ctrl : directed self-checking bench for vend_state_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_vend_state_ctrl;

   localparam int CW = 6;

   logic          clk;
   logic          rst_n;
   logic          coin_5;
   logic          coin_10;
   logic          cancel;
   logic [1:0]    current_state;
   logic [CW-1:0] change_amt;
   logic [CW-1:0] credit;
   logic          coin_reject;
   logic          busy;

   int errors = 0;
   int checks = 0;

   vend_state_ctrl #(
      .PRICE          (15),
      .CREDIT_W       (CW),
      .HOLD_CYCLES    (4),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .coin_5        (coin_5),
      .coin_10       (coin_10),
      .cancel        (cancel),
      .current_state (current_state),
      .change_amt    (change_amt),
      .credit        (credit),
      .coin_reject   (coin_reject),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".state"},  32'(current_state), 0);
      chk({tag, ".credit"}, 32'(credit), 0);
      chk({tag, ".change"}, 32'(change_amt), 0);
      chk({tag, ".busy"},   32'(busy), 0);
   endtask

   initial begin
      rst_n   = 1'b0;
      coin_5  = 1'b0;
      coin_10 = 1'b0;
      cancel  = 1'b0;

      // Reset held across three edges
      repeat (3) @(posedge clk);
      #1;
      chk_idle("rst_held");
      chk("rst_held.reject", 32'(coin_reject), 0);
      rst_n = 1'b1;
      tick();
      chk_idle("rst_rel");
      chk("rst_rel.reject", 32'(coin_reject), 0);

      // Exact vend: 10, gap, 5
      coin_10 = 1'b1; tick(); coin_10 = 1'b0;
      chk("ev.state1",  32'(current_state), 0);
      chk("ev.credit1", 32'(credit), 10);
      chk("ev.busy1",   32'(busy), 0);
      tick();
      chk("ev.gap_credit", 32'(credit), 10);
      coin_5 = 1'b1; tick(); coin_5 = 1'b0;
      chk("ev.vend_state",  32'(current_state), 2);
      chk("ev.vend_change", 32'(change_amt), 0);
      chk("ev.vend_credit", 32'(credit), 15);
      chk("ev.vend_busy",   32'(busy), 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ev.hold_state", 32'(current_state), 2);
      end
      tick();
      chk_idle("ev.done");

      // Vend with change: 10 + 10
      coin_10 = 1'b1; tick(); tick(); coin_10 = 1'b0;
      chk("vc.state",  32'(current_state), 3);
      chk("vc.credit", 32'(credit), 20);
      chk("vc.change", 32'(change_amt), 5);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("vc.hold_state",  32'(current_state), 3);
         chk("vc.hold_change", 32'(change_amt), 5);
      end
      tick();
      chk_idle("vc.done");

      // Cancel refund
      coin_5 = 1'b1; tick(); coin_5 = 1'b0;
      chk("cr.credit", 32'(credit), 5);
      cancel = 1'b1; tick(); cancel = 1'b0;
      chk("cr.state",  32'(current_state), 1);
      chk("cr.change", 32'(change_amt), 5);
      chk("cr.busy",   32'(busy), 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("cr.hold_state", 32'(current_state), 1);
      end
      tick();
      chk_idle("cr.done");

      // Cancel in IDLE is ignored
      cancel = 1'b1; tick(); cancel = 1'b0;
      chk_idle("ci");

      // Timeout: refund exactly 20 cycles after the coin
      coin_5 = 1'b1; tick(); coin_5 = 1'b0;
      repeat (19) tick();
      chk("to.before_state", 32'(current_state), 0);
      chk("to.before_credit", 32'(credit), 5);
      tick();
      chk("to.state",  32'(current_state), 1);
      chk("to.change", 32'(change_amt), 5);
      repeat (3) tick();
      chk("to.hold_state", 32'(current_state), 1);
      tick();
      chk_idle("to.done");

      // Timeout restart: second coin at cycle 10
      coin_5 = 1'b1; tick(); coin_5 = 1'b0;
      repeat (9) tick();
      coin_5 = 1'b1; tick(); coin_5 = 1'b0;
      chk("tr.credit", 32'(credit), 10);
      repeat (19) tick();
      chk("tr.before_state", 32'(current_state), 0);
      tick();
      chk("tr.state",  32'(current_state), 1);
      chk("tr.change", 32'(change_amt), 10);
      repeat (4) tick();
      chk_idle("tr.done");

      // Coin during VEND is rejected
      coin_10 = 1'b1; tick(); coin_10 = 1'b0;
      coin_5  = 1'b1; tick(); coin_5  = 1'b0;
      chk("rv.state", 32'(current_state), 2);
      coin_5 = 1'b1; tick(); coin_5 = 1'b0;
      chk("rv.reject", 32'(coin_reject), 1);
      chk("rv.credit", 32'(credit), 15);
      chk("rv.state2", 32'(current_state), 2);
      tick();
      chk("rv.reject_clr", 32'(coin_reject), 0);
      tick();
      tick();
      chk_idle("rv.done");

      // Both coins together in IDLE
      coin_5 = 1'b1; coin_10 = 1'b1; tick(); coin_5 = 1'b0; coin_10 = 1'b0;
      chk("bc.reject", 32'(coin_reject), 1);
      chk_idle("bc");
      tick();
      chk("bc.reject_clr", 32'(coin_reject), 0);

      // Coin coincident with cancel in COLLECT: coin refused, refund taken
      coin_5 = 1'b1; tick();
      cancel = 1'b1; tick(); coin_5 = 1'b0; cancel = 1'b0;
      chk("cc.reject", 32'(coin_reject), 1);
      chk("cc.state",  32'(current_state), 1);
      chk("cc.change", 32'(change_amt), 5);
      repeat (4) tick();
      chk_idle("cc.done");

      // Asynchronous reset in 2nd VEND cycle
      coin_10 = 1'b1; tick(); coin_10 = 1'b0;
      coin_5  = 1'b1; tick(); coin_5  = 1'b0;
      chk("ar.vend1", 32'(current_state), 2);
      tick();
      chk("ar.vend2", 32'(current_state), 2);
      #2 rst_n = 1'b0;
      #1;
      chk_idle("ar.async");
      chk("ar.reject", 32'(coin_reject), 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk_idle("ar.after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
